// File: rtl/shift_right_seq_if.sv
// shift_right_seq_if: request/result bundle for the multi-cycle right shifter.
//   ctrl_start      request, sampled only while the shifter is accepting
//   data_operandA   32-bit value to shift
//   ctrl_shiftamt   5-bit shift amount
//   ctrl_arith      1 = arithmetic fill, 0 = logical fill
//   data_result     working/final value
//   data_resultRDY  single-cycle completion pulse
//   busy            high while shift stages are being applied
// master = requester (processor side), slave = shifter.
interface shift_right_seq_if;
  localparam int unsigned DataW = 32;
  localparam int unsigned AmtW  = 5;

  logic             ctrl_start;
  logic [DataW-1:0] data_operandA;
  logic [AmtW-1:0]  ctrl_shiftamt;
  logic             ctrl_arith;
  logic [DataW-1:0] data_result;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output ctrl_start, data_operandA, ctrl_shiftamt, ctrl_arith,
    input  data_result, data_resultRDY, busy
  );

  modport slave (
    input  ctrl_start, data_operandA, ctrl_shiftamt, ctrl_arith,
    output data_result, data_resultRDY, busy
  );
endinterface

// File: rtl/shift_right_seq.sv
// shift_right_seq: multi-cycle 32-bit right shifter (srl/sra), one
// power-of-two stage per clock, completion signalled by a one-cycle pulse.
// Ports:
//   clock  single clock, rising edge
//   reset  asynchronous, active-high; clears all state
//   bus    shift_right_seq_if.slave (request inputs, result/ready/busy outputs)
// Build option:
//   SHIFT_RIGHT_SEQ_EARLY_EXIT_EN  when defined, only stages whose shift-amount
//   bit is set are visited (highest first), so latency tracks popcount of the
//   shift amount; a zero shift amount completes straight from acceptance.
//   When undefined, the fixed 16/8/4/2/1 five-stage schedule is used.
module shift_right_seq (
  input  logic              clock,
  input  logic              reset,
  shift_right_seq_if.slave  bus
);

  localparam int unsigned DataW = 32;
  localparam int unsigned AmtW  = 5;
  localparam int unsigned IdxW  = 3;
  localparam logic [DataW-1:0] AllOnes = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DataW-1:0] acc_q,   acc_d;
  logic [AmtW-1:0]  rem_q,   rem_d;
  logic             fill_q,  fill_d;
  logic             rdy_q,   rdy_d;
  logic             busy_q,  busy_d;
`ifndef SHIFT_RIGHT_SEQ_EARLY_EXIT_EN
  logic [IdxW-1:0]  idx_q,   idx_d;
`endif

  logic [IdxW-1:0]  stage_idx;
  logic [AmtW-1:0]  stage_sh;
  logic [DataW-1:0] stage_val;

  // Stage selection: fixed countdown, or the highest remaining set bit.
`ifdef SHIFT_RIGHT_SEQ_EARLY_EXIT_EN
  always_comb begin
    stage_idx = '0;
    for (int i = 0; i < int'(AmtW); i++) begin
      if (rem_q[i]) stage_idx = IdxW'(i);
    end
  end
`else
  assign stage_idx = idx_q;
`endif

  // One power-of-two shift (1..16) with vacated high bits set to the fill bit.
  always_comb begin
    stage_sh  = AmtW'(1) << stage_idx;
    stage_val = (acc_q >> stage_sh) | (fill_q ? ~(AllOnes >> stage_sh) : '0);
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    fill_d  = fill_q;
`ifndef SHIFT_RIGHT_SEQ_EARLY_EXIT_EN
    idx_d   = idx_q;
`endif

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.ctrl_start) begin
          acc_d  = bus.data_operandA;
          rem_d  = bus.ctrl_shiftamt;
          fill_d = bus.ctrl_arith & bus.data_operandA[DataW-1];
`ifdef SHIFT_RIGHT_SEQ_EARLY_EXIT_EN
          state_d = (bus.ctrl_shiftamt == '0) ? DONE : SHIFT;
`else
          idx_d   = IdxW'(AmtW - 1);
          state_d = SHIFT;
`endif
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      SHIFT: begin
`ifdef SHIFT_RIGHT_SEQ_EARLY_EXIT_EN
        // rem is never zero here: a zero amount bypasses SHIFT entirely.
        acc_d = stage_val;
        rem_d = rem_q & ~(AmtW'(1) << stage_idx);
        if (rem_d == '0) state_d = DONE;
`else
        if (rem_q[idx_q]) acc_d = stage_val;
        if (idx_q == '0) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q - IdxW'(1);
        end
`endif
      end

      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they line up with it.
    rdy_d  = (state_d == DONE);
    busy_d = (state_d == SHIFT);
  end

  // State and datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      fill_q  <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifndef SHIFT_RIGHT_SEQ_EARLY_EXIT_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      fill_q  <= fill_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
`ifndef SHIFT_RIGHT_SEQ_EARLY_EXIT_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign bus.data_result    = acc_q;
  assign bus.data_resultRDY = rdy_q;
  assign bus.busy           = busy_q;

endmodule
